// File: rtl/uart_byte_processor.sv
// UART byte processor: buffers received words in a small FIFO, applies a
// mode-selected transform and feeds the transmitter one word at a time.
module uart_byte_processor #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   r_data,
    input  logic              tx_done_tick,
    input  logic [1:0]        mode,
    output logic [DBIT-1:0]   w_data,
    output logic              tx_start,
    output logic              busy,
    output logic [FIFO_W:0]   fifo_count,
    output logic              overflow
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam logic [DBIT-1:0] OFF = DBIT'(OFFSET);
    localparam logic [FIFO_W:0] FULL_COUNT = (FIFO_W + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W:0]   count;
    logic [0:0]        state;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic [DBIT-1:0]   head;
    logic [DBIT-1:0]   result;

    // Handshake: tx_start pulses for one cycle alongside a new w_data; the
    // processor then stays busy until the transmitter answers with tx_done_tick.
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    assign push  = rx_done_tick && (!full || pop);
    assign head  = mem[rd_ptr];

    assign busy       = (state == WAIT);
    assign fifo_count = count;

    always_comb begin
        result = head;
        case (mode)
            2'b00:   result = head;
            2'b01:   result = head + OFF;
            2'b10:   result = ~head;
            2'b11:   result = head - OFF;
            default: result = head;
        endcase
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            w_data   <= '0;
            tx_start <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rx_done_tick && full && !pop) begin
                overflow <= 1'b1;
            end

            tx_start <= pop;
            if (pop) begin
                w_data <= result;
            end

            case (state)
                IDLE:    if (pop) state <= WAIT;
                WAIT:    if (tx_done_tick) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_processor.sv
// Directed bench for uart_byte_processor: transforms, FIFO ordering,
// overflow, full-with-pop acceptance and mid-transfer reset.
module tb_uart_byte_processor;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] r_data;
    logic       tx_done_tick;
    logic [1:0] mode;
    logic [7:0] w_data;
    logic       tx_start;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    uart_byte_processor #(.DBIT(8), .FIFO_W(2), .OFFSET(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .r_data       (r_data),
        .tx_done_tick (tx_done_tick),
        .mode         (mode),
        .w_data       (w_data),
        .tx_start     (tx_start),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_done_tick = 1'b1;
        r_data = d;
        step();
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
    endtask

    // Single word issued from an idle, empty processor, then completed.
    task automatic xform(input string tag, input logic [1:0] m, input logic [7:0] d,
                         input logic [7:0] exp);
        mode = m;
        pulse_rx(d);
        step();
        check({tag, "_start"}, tx_start, 1);
        check({tag, "_data"}, w_data, exp);
        mode = ~m;
        step();
        check({tag, "_hold"}, w_data, exp);
        pulse_tx();
    endtask

    initial begin
        reset = 1'b1;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        r_data = 8'h00;
        mode = 2'b00;
        step();
        step();
        reset = 1'b0;
        check("rst_w_data", w_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);

        // Latency: rx in cycle N, tx_start in N+2
        mode = 2'b01;
        pulse_rx(8'h41);
        check("lat_n1_start", tx_start, 0);
        check("lat_n1_count", fifo_count, 1);
        step();
        check("lat_n2_start", tx_start, 1);
        check("lat_n2_data", w_data, 8'h42);
        check("lat_n2_busy", busy, 1);
        check("lat_n2_count", fifo_count, 0);
        step();
        check("lat_pulse_once", tx_start, 0);
        check("lat_busy_hold", busy, 1);
        pulse_tx();
        check("lat_busy_drop", busy, 0);
        check("lat_data_hold", w_data, 8'h42);
        step();
        check("lat_no_restart", tx_start, 0);

        xform("add_wrap", 2'b01, 8'hFF, 8'h00);
        xform("sub_wrap", 2'b11, 8'h00, 8'hFF);
        xform("invert", 2'b10, 8'h5A, 8'hA5);
        xform("pass", 2'b00, 8'h37, 8'h37);

        // Four back-to-back words, drained in order
        mode = 2'b00;
        pulse_rx(8'h10);
        pulse_rx(8'h11);
        check("q4_first_start", tx_start, 1);
        check("q4_first_data", w_data, 8'h10);
        pulse_rx(8'h12);
        pulse_rx(8'h13);
        check("q4_count3", fifo_count, 3);
        check("q4_busy", busy, 1);
        for (int i = 1; i < 4; i++) begin
            pulse_tx();
            check("q4_gap_start", tx_start, 0);
            step();
            check("q4_start", tx_start, 1);
            check("q4_data", w_data, 8'h10 + 8'(i));
            check("q4_count", fifo_count, 3 - i);
        end
        pulse_tx();
        check("q4_overflow", overflow, 0);
        check("q4_idle", busy, 0);

        // Fill to full (one issued + four buffered)
        for (int i = 0; i < 5; i++) pulse_rx(8'h20 + 8'(i));
        check("full_count", fifo_count, 4);
        check("full_overflow0", overflow, 0);
        pulse_tx();
        // Push coinciding with a pop while full is accepted
        pulse_rx(8'h25);
        check("coinc_start", tx_start, 1);
        check("coinc_data", w_data, 8'h21);
        check("coinc_count", fifo_count, 4);
        check("coinc_overflow", overflow, 0);
        // Full and waiting: dropped
        pulse_rx(8'h26);
        check("drop_count", fifo_count, 4);
        check("drop_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            pulse_tx();
            step();
            check("drain_data", w_data, 8'h22 + 8'(i));
            check("drain_count", fifo_count, 3 - i);
            check("drain_overflow", overflow, 1);
        end
        pulse_tx();
        step();
        check("drain_empty_start", tx_start, 0);

        // Reset while busy with two words buffered
        mode = 2'b10;
        pulse_rx(8'h30);
        pulse_rx(8'h31);
        pulse_rx(8'h32);
        check("mid_count", fifo_count, 2);
        check("mid_busy", busy, 1);
        check("mid_data", w_data, 8'hCF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_data", w_data, 0);
        check("mid_rst_overflow", overflow, 0);
        pulse_tx();
        check("late_tx_start", tx_start, 0);
        step();
        check("late_tx_start2", tx_start, 0);
        check("late_tx_busy", busy, 0);
        check("late_tx_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_processor.md
Name: uart_byte_processor

Overview:
- Sits between the UART receiver and transmitter as a parametrised successor to the single-byte loopback checker.
- Buffers received words in a FIFO, transforms each word according to a runtime-selectable mode, and hands results to the transmitter one at a time.
- Waits for the transmitter's completion tick before issuing the next word, so no bytes are lost while the transmitter is busy.

Parameters:
- DBIT, 8, data word width in bits (matches the UART data width).
- FIFO_W, 2, FIFO address width; depth = 2**FIFO_W words.
- OFFSET, 1, constant used by the add and subtract modes; truncated to DBIT bits.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_done_tick  input  1  one-cycle pulse: r_data holds a valid received word.
- r_data  input  DBIT  received word.
- tx_done_tick  input  1  one-cycle pulse: transmitter finished the current word.
- mode  input  2  transform select: 00 pass, 01 add OFFSET, 10 bitwise invert, 11 subtract OFFSET.
- w_data  output  DBIT  transformed word presented to the transmitter (registered).
- tx_start  output  1  one-cycle pulse requesting transmission of w_data (registered).
- busy  output  1  high while waiting for tx_done_tick.
- fifo_count  output  FIFO_W+1  number of words currently buffered, 0..2**FIFO_W.
- overflow  output  1  sticky flag: a received word was dropped because the FIFO was full.

Behaviour:
- Reset is synchronous and active-high. At reset: w_data=0, tx_start=0, busy=0, fifo_count=0, overflow=0, FSM goes to IDLE, FIFO pointers clear. Buffered contents are discarded.
- Reset asserted mid-transfer aborts the transfer. A tx_done_tick arriving after reset deasserts, while in IDLE, is ignored.
- FIFO push: on rx_done_tick, r_data is written at the write pointer when the FIFO is not full.
  - Full, no pop this cycle: the word is dropped and overflow is set. overflow stays set until reset.
  - Full, pop in the same cycle: the push is accepted and fifo_count is unchanged.
- FIFO pop: performed only by the FSM, as below. The FIFO head is read combinationally.
- Pointers wrap modulo 2**FIFO_W. fifo_count = pushes − pops; simultaneous push and pop leaves it unchanged.
- FSM states:
  - IDLE: if fifo_count != 0, pop the head, register w_data <= f(head, mode), pulse tx_start for exactly one cycle, go to WAIT. Otherwise stay in IDLE with tx_start=0.
  - WAIT: busy=1 and tx_start=0. On tx_done_tick go to IDLE; busy drops in the cycle after the tick. tx_done_tick seen in IDLE is ignored.
- Transform f:
  - mode is sampled in the cycle of the pop; a mode change never alters a word already issued.
  - 00: f = head.
  - 01: f = (head + OFFSET) mod 2**DBIT.
  - 10: f = ~head.
  - 11: f = (head − OFFSET) mod 2**DBIT.
- Latency: rx_done_tick in cycle N with the FIFO empty and FSM in IDLE gives tx_start=1 and w_data valid in cycle N+2.
- Back-to-back: the next tx_start comes no earlier than 2 cycles after tx_done_tick (IDLE, then issue).
- w_data holds its value between issues and after tx_done_tick.
- rx_done_tick and tx_done_tick in the same cycle are handled independently (push and FSM transition both occur).

Test Plan:
- Reset, mode=01, single rx_done_tick with r_data=0x41 -> tx_start single pulse 2 cycles later, w_data=0x42, busy=1 until tx_done_tick, fifo_count back to 0.
- mode=01, r_data=0xFF -> w_data=0x00 (wrap). mode=11, r_data=0x00 -> w_data=0xFF. mode=10, r_data=0x5A -> w_data=0xA5. mode=00, r_data=0x37 -> w_data=0x37.
- Four rx ticks (0x10,0x11,0x12,0x13) with no tx_done -> first issued, fifo_count=3. Three more tx_done_ticks -> remaining words issued in order; fifo_count counts 3,2,1,0; overflow=0.
- Default depth 4, hold tx_done low, six rx ticks -> five accepted (one issued plus 4 buffered), sixth dropped, overflow=1 and stays 1. Subsequent drain order is intact.
- FIFO full with an rx_done_tick coinciding with a pop -> word accepted, fifo_count stays 4, overflow stays 0.
- Assert reset while busy with 2 words buffered -> next cycle tx_start=0, busy=0, fifo_count=0, w_data=0. A following tx_done_tick produces no tx_start.
